// File: rtl/gate_unit_arbiter_if.sv
// rtl/gate_unit_arbiter_if.sv - requester, gate-unit and result signals of the gate unit arbiter
// master: requesters plus the gate unit; slave: the arbiter itself.
interface gate_unit_arbiter_if;
  logic       iReq0;
  logic [2:0] iOp0;
  logic       iReq1;
  logic [2:0] iOp1;
  logic [7:0] iRes;
  logic       oA;
  logic       oB;
  logic       oC;
  logic       oGnt0;
  logic       oGnt1;
  logic [7:0] oRes;
  logic       oValid0;
  logic       oValid1;
  logic       oBusy;

  modport master (
    output iReq0, iOp0, iReq1, iOp1, iRes,
    input  oA, oB, oC, oGnt0, oGnt1, oRes, oValid0, oValid1, oBusy
  );

  modport slave (
    input  iReq0, iOp0, iReq1, iOp1, iRes,
    output oA, oB, oC, oGnt0, oGnt1, oRes, oValid0, oValid1, oBusy
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter sharing one 3-input gate unit between two requesters
// Operands are held for HOLD_CYCLES before the gate result is captured and handed back.
module gate_unit_arbiter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic          iClk,
  input  logic          iRst,
  gate_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_ptr;
  logic       r_winner;
  logic       r_a;
  logic       r_b;
  logic       r_c;
  logic [7:0] r_res;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_valid0;
  logic       r_valid1;
  logic       r_busy;

  logic       w_any_req;
  logic       w_pick;
  logic [2:0] w_op;

  // Only a tie consults the pointer; a lone request always wins.
  always_comb begin
    w_any_req = bus.iReq0 | bus.iReq1;
    w_pick    = (bus.iReq0 & bus.iReq1) ? r_ptr : bus.iReq1;
    w_op      = w_pick ? bus.iOp1 : bus.iOp0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_ptr    <= 1'b0;
      r_winner <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_c      <= 1'b0;
      r_res    <= 8'h00;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_winner          <= w_pick;
            {r_a, r_b, r_c}   <= w_op;
            r_cnt             <= LP_HOLD_LOAD;
            r_gnt0            <= ~w_pick;
            r_gnt1            <= w_pick;
            r_busy            <= 1'b1;
            r_state           <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt == 4'd0) begin
            r_res    <= bus.iRes;
            r_valid0 <= ~r_winner;
            r_valid1 <= r_winner;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          r_busy   <= 1'b0;
          r_ptr    <= ~r_winner;
          r_state  <= IDLE;
        end
        default: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.oA      = r_a;
  assign bus.oB      = r_b;
  assign bus.oC      = r_c;
  assign bus.oGnt0   = r_gnt0;
  assign bus.oGnt1   = r_gnt1;
  assign bus.oRes    = r_res;
  assign bus.oValid0 = r_valid0;
  assign bus.oValid1 = r_valid1;
  assign bus.oBusy   = r_busy;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - bench for gate_unit_arbiter at HOLD_CYCLES 1 and 4
// Transaction-level model predicts every output each cycle; directed literals pin the model.
module tb_gate_unit_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gate_unit_arbiter_if ifa ();
  gate_unit_arbiter_if ifb ();

  gate_unit_arbiter #(.HOLD_CYCLES(1)) u_h1 (.iClk(clk), .iRst(rst), .bus(ifa));
  gate_unit_arbiter #(.HOLD_CYCLES(4)) u_h4 (.iClk(clk), .iRst(rst), .bus(ifb));

  function automatic logic [7:0] gate3(input logic [2:0] abc);
    logic a, b, c;
    a = abc[2]; b = abc[1]; c = abc[0];
    return {a & b & c, ~(a & b & c), a | b | c, ~(a | b | c), ~a, ~b, a ^ b ^ c, ~(a ^ b ^ c)};
  endfunction

  assign ifa.iRes = gate3({ifa.oA, ifa.oB, ifa.oC});
  assign ifb.iRes = gate3({ifb.oA, ifb.oB, ifb.oC});

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: remaining grant cycles per instance; last one is the result cycle.
  int         m_hold [2] = '{1, 4};
  int         m_left [2] = '{0, 0};
  logic       m_ptr  [2] = '{1'b0, 1'b0};
  logic       m_win  [2] = '{1'b0, 1'b0};
  logic [2:0] m_ops  [2] = '{3'd0, 3'd0};
  logic [7:0] m_res  [2] = '{8'd0, 8'd0};
  logic       m_rst_last = 1'b1;
  logic       m_started  = 1'b0;

  task automatic model_step(input int k, input logic q0, input logic [2:0] p0,
                            input logic q1, input logic [2:0] p1);
    if (rst) begin
      m_left[k] = 0; m_ptr[k] = 1'b0; m_win[k] = 1'b0; m_ops[k] = 3'd0; m_res[k] = 8'd0;
    end else if (m_left[k] == 0) begin
      if (q0 || q1) begin
        m_win[k]  = (q0 && q1) ? m_ptr[k] : q1;
        m_ops[k]  = m_win[k] ? p1 : p0;
        m_left[k] = m_hold[k] + 1;
      end
    end else begin
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 1) m_res[k] = gate3(m_ops[k]);
      if (m_left[k] == 0) m_ptr[k] = ~m_win[k];
    end
  endtask

  function automatic logic [15:0] m_expect(input int k);
    logic act_g, last;
    act_g = (m_left[k] > 0);
    last  = (m_left[k] == 1);
    return {act_g & ~m_win[k], act_g & m_win[k], last & ~m_win[k], last & m_win[k],
            act_g, m_ops[k], m_res[k]};
  endfunction

  always @(posedge clk) begin
    model_step(0, ifa.iReq0, ifa.iOp0, ifa.iReq1, ifa.iOp1);
    model_step(1, ifb.iReq0, ifb.iOp0, ifb.iReq1, ifb.iOp1);
    m_rst_last = rst;
    m_started  = 1'b1;
  end

  logic [15:0] prev_vec [2];

  task automatic compare_inst(input int k, input logic [15:0] act);
    string tag;
    tag = (k == 0) ? "h1" : "h4";
    chk({tag, "_model"}, act, m_expect(k));
    chk({tag, "_gnt_mutex"}, 16'(act[15] & act[14]), 16'd0);
    chk({tag, "_valid_no_gnt"}, 16'((act[13] & ~act[15]) | (act[12] & ~act[14])), 16'd0);
    chk({tag, "_valid_width"}, 16'((act[13] & prev_vec[k][13]) | (act[12] & prev_vec[k][12])), 16'd0);
    chk({tag, "_res_hold"},
        16'((act[7:0] != prev_vec[k][7:0]) && !(act[13] | act[12]) && !m_rst_last), 16'd0);
    prev_vec[k] = act;
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      compare_inst(0, {ifa.oGnt0, ifa.oGnt1, ifa.oValid0, ifa.oValid1, ifa.oBusy,
                       ifa.oA, ifa.oB, ifa.oC, ifa.oRes});
      compare_inst(1, {ifb.oGnt0, ifb.oGnt1, ifb.oValid0, ifb.oValid1, ifb.oBusy,
                       ifb.oA, ifb.oB, ifb.oC, ifb.oRes});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    prev_vec[0] = 16'd0;
    prev_vec[1] = 16'd0;
    ifa.iReq0 = 0; ifa.iOp0 = 0; ifa.iReq1 = 0; ifa.iOp1 = 0;
    ifb.iReq0 = 0; ifb.iOp0 = 0; ifb.iReq1 = 0; ifb.iOp1 = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    chk("idle_a", {ifa.oGnt0, ifa.oGnt1, ifa.oValid0, ifa.oValid1, ifa.oBusy,
                   ifa.oA, ifa.oB, ifa.oC, ifa.oRes}, 16'd0);
    chk("idle_b", {ifb.oGnt0, ifb.oGnt1, ifb.oValid0, ifb.oValid1, ifb.oBusy,
                   ifb.oA, ifb.oB, ifb.oC, ifb.oRes}, 16'd0);

    // single request, HOLD_CYCLES=1
    ifa.iReq0 = 1; ifa.iOp0 = 3'b110;
    step();
    ifa.iReq0 = 0; ifa.iOp0 = 3'b001;
    chk("h1_t1", {ifa.oGnt0, ifa.oValid0, ifa.oBusy}, 16'b101);
    step();
    chk("h1_t2", {ifa.oGnt0, ifa.oValid0}, 16'b11);
    chk("h1_res", ifa.oRes, 16'h61);
    step();
    chk("h1_t3", {ifa.oBusy, ifa.oGnt0, ifa.oValid0}, 16'd0);
    chk("h1_res_hold", ifa.oRes, 16'h61);

    // both requests held: alternate from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.iReq0 = 1; ifa.iOp0 = 3'b111; ifa.iReq1 = 1; ifa.iOp1 = 3'b000;
    for (int n = 0; n < 4; n++) begin
      found = 0;
      for (int w = 0; w < 8 && !found; w++) begin
        step();
        if (ifa.oValid0 || ifa.oValid1) found = 1;
      end
      chk("rr_timeout", 16'(found), 16'd1);
      chk("rr_who", {ifa.oValid0, ifa.oValid1}, (n % 2 == 0) ? 16'b10 : 16'b01);
      chk("rr_res", ifa.oRes, (n % 2 == 0) ? 16'hA2 : 16'h5D);
    end
    ifa.iReq0 = 0; ifa.iReq1 = 0;
    repeat (3) step();

    // HOLD_CYCLES=4, one-cycle pulse, operands change after grant
    ifb.iReq1 = 1; ifb.iOp1 = 3'b000;
    step();
    ifb.iReq1 = 0; ifb.iOp1 = 3'b111;
    for (int k = 1; k <= 5; k++) begin
      chk("h4_gnt1", 16'(ifb.oGnt1), 16'd1);
      chk("h4_valid1", 16'(ifb.oValid1), 16'(k == 5));
      if (k == 3) chk("h4_ops_latched", {ifb.oA, ifb.oB, ifb.oC}, 16'd0);
      step();
    end
    chk("h4_after", {ifb.oGnt1, ifb.oBusy}, 16'd0);
    chk("h4_res", ifb.oRes, 16'h5D);

    // reset aborts a requester-1 transaction
    ifb.iReq1 = 1; ifb.iOp1 = 3'b010;
    step();
    ifb.iReq0 = 1; ifb.iOp0 = 3'b101;
    step();
    chk("abort_pre", 16'(ifb.oGnt1), 16'd1);
    rst = 1'b1;
    step();
    chk("abort_reset", {ifb.oGnt0, ifb.oGnt1, ifb.oValid0, ifb.oValid1, ifb.oBusy,
                        ifb.oA, ifb.oB, ifb.oC, ifb.oRes}, 16'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_winner", {ifb.oGnt0, ifb.oGnt1}, 16'b10);
    found = 0;
    for (int w = 0; w < 10 && !found; w++) begin
      step();
      if (ifb.oValid0 || ifb.oValid1) found = 1;
    end
    chk("post_reset_timeout", 16'(found), 16'd1);
    chk("post_reset_valid", {ifb.oValid0, ifb.oValid1}, 16'b10);
    chk("post_reset_res", ifb.oRes, 16'(gate3(3'b101)));
    ifb.iReq0 = 0; ifb.iReq1 = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_unit_arbiter.md
GATE_UNIT_ARBITER -- requirements
Module: gate_unit_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, legal range 1..15: number of cycles operands are held on the gate unit before its result is sampled.
REQ-002 iClk  in  1  single system clock; all state updates on rising edge.
REQ-003 iRst  in  1  synchronous, active-high reset.
REQ-004 iReq0  in  1  requester 0 request level.
REQ-005 iOp0  in  3  requester 0 operands: [2]=A, [1]=B, [0]=C.
REQ-006 iReq1  in  1  requester 1 request level.
REQ-007 iOp1  in  3  requester 1 operands, same bit order as iOp0.
REQ-008 oA, oB, oC  out  1 each  registered operands driven to the shared 3-input gate unit.
REQ-009 iRes  in  8  gate unit outputs: [7]AND [6]NAND [5]OR [4]NOR [3]NOTA [2]NOTB [1]XOR [0]XNOR.
REQ-010 oGnt0, oGnt1  out  1 each  grant to requester 0 / 1; at most one high in any cycle.
REQ-011 oRes  out  8  registered result of the last completed transaction, same bit order as iRes.
REQ-012 oValid0, oValid1  out  1 each  one-cycle pulse: oRes is valid for requester 0 / 1.
REQ-013 oBusy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-015 IDLE: if any iReq is high, winner SHALL be latched, the winner's iOp latched into oA/oB/oC, hold counter loaded with HOLD_CYCLES-1, next state HOLD; otherwise stay IDLE with oA/oB/oC unchanged.
REQ-016 Arbitration SHALL be round-robin: if only one request is high it wins; if both are high the requester indicated by the priority pointer wins.
REQ-017 Priority pointer SHALL move to the non-winning requester on exit from DONE; it SHALL not change otherwise.
REQ-018 HOLD: winner's oGnt high; if counter = 0 then oRes <= iRes and next state DONE; else counter decrements.
REQ-019 DONE: winner's oGnt and oValid high for exactly one cycle; next state IDLE unconditionally.
REQ-020 Latency: request sampled in IDLE at cycle t -> oGnt high t+1..t+HOLD_CYCLES+1, oValid pulse at t+HOLD_CYCLES+1, IDLE again at t+HOLD_CYCLES+2; max throughput one transaction per HOLD_CYCLES+2 cycles.
REQ-021 Operands latched at grant; changes on iOp or deassertion of iReq during HOLD/DONE SHALL not alter oA/oB/oC nor abort the transaction.
REQ-022 Requests arriving while oBusy is high SHALL be ignored until IDLE; a request still high in IDLE after its oValid SHALL be re-arbitrated as a new transaction.
REQ-023 oRes SHALL hold its value between transactions; it changes only on the HOLD->DONE transition.
REQ-024 oValid0 and oValid1 SHALL never be high in the same cycle; oValidN high implies oGntN high.

Reset
REQ-025 While iRst is high, on each clock: state IDLE, counter 0, priority pointer = requester 0, oA=oB=oC=0, oRes=8'h00, oGnt0=oGnt1=0, oValid0=oValid1=0, oBusy=0.
REQ-026 iRst asserted mid-transaction SHALL abort it with no oValid pulse; the first transaction after reset SHALL follow REQ-016 with pointer at requester 0.
REQ-027 iRst SHALL take priority over all other inputs in the same cycle.

Verification (bench instantiates the team's 3-input gate module between oA/oB/oC and iRes)
REQ-028 Reset then idle 5 cycles -> all outputs 0, oBusy 0, no grant.
REQ-029 HOLD_CYCLES=1, iReq0=1, iOp0=3'b110 at cycle t -> oGnt0 high t+1..t+2, oValid0 at t+2, oRes=8'h61, oBusy low at t+3.
REQ-030 Both requests held high, iOp0=3'b111, iOp1=3'b000 -> grants alternate 0,1,0,1; oRes alternates 8'hA2 / 8'h5D with matching oValid0/oValid1.
REQ-031 HOLD_CYCLES=4, iReq1 pulse of 1 cycle with iOp1=3'b000, iOp1 changed to 3'b111 next cycle -> oGnt1 5 cycles, oValid1 at t+5, oRes=8'h5D.
REQ-032 iRst asserted in HOLD of a requester-1 transaction -> next cycle all outputs at reset values, no oValid1; with both requests high after reset requester 0 wins.
REQ-033 Assertions throughout: oGnt0&oGnt1 never high; oValid pulse width 1; oRes changes only at HOLD->DONE.
